// File: rtl/ma_mem_arbiter.sv
// Shares one byte-wide synchronous SRAM between two 32-bit word requesters.
// Each word access becomes four big-endian byte beats; grants are round-robin or A-priority.
module ma_mem_arbiter #(
  parameter int ADDR_W     = 12,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic              a_req_we,
  input  logic [ADDR_W-1:0] a_req_addr,
  input  logic [31:0]       a_req_wdata,
  output logic              a_rsp_valid,
  output logic [31:0]       a_rsp_rdata,
  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic              b_req_we,
  input  logic [ADDR_W-1:0] b_req_addr,
  input  logic [31:0]       b_req_wdata,
  output logic              b_rsp_valid,
  output logic [31:0]       b_rsp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {IDLE, BEAT, FLUSH, RESP} state_t;

  state_t            state;
  logic [1:0]        k;
  logic              last_grant;  // 1 = port B was granted last
  logic              port_b;
  logic [23:0]       wbuf;
  logic [23:0]       rbuf;
  logic              pick_b;
  logic              accept;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;

  // Ready is gated by rst_n so nothing is granted while reset is held.
  always_comb begin
    pick_b      = b_req_valid && (!a_req_valid || (!FIXED_PRIO && !last_grant));
    accept      = rst_n && (state == IDLE) && (a_req_valid || b_req_valid);
    a_req_ready = accept && !pick_b;
    b_req_ready = accept && pick_b;
    sel_we      = pick_b ? b_req_we    : a_req_we;
    sel_addr    = pick_b ? b_req_addr  : a_req_addr;
    sel_wdata   = pick_b ? b_req_wdata : a_req_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      k           <= 2'd0;
      last_grant  <= 1'b1;
      port_b      <= 1'b0;
      a_rsp_valid <= 1'b0;
      b_rsp_valid <= 1'b0;
      a_rsp_rdata <= 32'h0;
      b_rsp_rdata <= 32'h0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= 8'h00;
    end else begin
      a_rsp_valid <= 1'b0;
      b_rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= BEAT;
            k          <= 2'd0;
            port_b     <= pick_b;
            last_grant <= pick_b;
            mem_en     <= 1'b1;
            mem_we     <= sel_we;
            mem_addr   <= sel_addr;
            mem_wdata  <= sel_wdata[31:24];
          end
        end
        BEAT: begin
          k <= k + 2'd1;
          if (k == 2'd3) begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            // mem_we still holds the latched direction of this transaction
            if (mem_we) begin
              state <= RESP;
              if (port_b) begin
                b_rsp_valid <= 1'b1;
                b_rsp_rdata <= 32'h0;
              end else begin
                a_rsp_valid <= 1'b1;
                a_rsp_rdata <= 32'h0;
              end
            end else begin
              state <= FLUSH;
            end
          end else begin
            mem_addr  <= mem_addr + ADDR_W'(1);
            mem_wdata <= wbuf[23:16];
          end
        end
        FLUSH: begin
          state <= RESP;
          if (port_b) begin
            b_rsp_valid <= 1'b1;
            b_rsp_rdata <= {rbuf, mem_rdata};
          end else begin
            a_rsp_valid <= 1'b1;
            a_rsp_rdata <= {rbuf, mem_rdata};
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Byte shifters: store bytes leave MSB first, load bytes arrive one cycle behind their beat.
  always_ff @(posedge clk) begin
    if (accept)
      wbuf <= sel_wdata[23:0];
    else if (state == BEAT)
      wbuf <= {wbuf[15:0], 8'h00};
    if (state == BEAT && k != 2'd0)
      rbuf <= {rbuf[15:0], mem_rdata};
  end

endmodule

// File: tb/tb_ma_mem_arbiter.sv
// Bench for ma_mem_arbiter: a byte SRAM model plus a word-level reference memory,
// with directed scenarios and randomized back-to-back traffic.
module tb_ma_mem_arbiter;
  localparam int AW    = 12;
  localparam int DEPTH = 4096;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          a_req_valid, a_req_ready, a_req_we, a_rsp_valid;
  logic [AW-1:0] a_req_addr;
  logic [31:0]   a_req_wdata, a_rsp_rdata;
  logic          b_req_valid, b_req_ready, b_req_we, b_rsp_valid;
  logic [AW-1:0] b_req_addr;
  logic [31:0]   b_req_wdata, b_rsp_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata, mem_rdata;

  logic          f_a_req_valid, f_a_req_ready, f_a_req_we, f_a_rsp_valid;
  logic [AW-1:0] f_a_req_addr;
  logic [31:0]   f_a_req_wdata, f_a_rsp_rdata;
  logic          f_b_req_valid, f_b_req_ready, f_b_req_we, f_b_rsp_valid;
  logic [AW-1:0] f_b_req_addr;
  logic [31:0]   f_b_req_wdata, f_b_rsp_rdata;
  logic          f_mem_en, f_mem_we;
  logic [AW-1:0] f_mem_addr;
  logic [7:0]    f_mem_wdata, f_mem_rdata;
  assign f_mem_rdata = 8'h5A;

  ma_mem_arbiter #(.ADDR_W(AW), .FIXED_PRIO(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
    .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
    .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
    .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
    .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  ma_mem_arbiter #(.ADDR_W(AW), .FIXED_PRIO(1'b1)) u_fix (
    .clk(clk), .rst_n(rst_n),
    .a_req_valid(f_a_req_valid), .a_req_ready(f_a_req_ready), .a_req_we(f_a_req_we),
    .a_req_addr(f_a_req_addr), .a_req_wdata(f_a_req_wdata),
    .a_rsp_valid(f_a_rsp_valid), .a_rsp_rdata(f_a_rsp_rdata),
    .b_req_valid(f_b_req_valid), .b_req_ready(f_b_req_ready), .b_req_we(f_b_req_we),
    .b_req_addr(f_b_req_addr), .b_req_wdata(f_b_req_wdata),
    .b_rsp_valid(f_b_rsp_valid), .b_rsp_rdata(f_b_rsp_rdata),
    .mem_en(f_mem_en), .mem_we(f_mem_we), .mem_addr(f_mem_addr),
    .mem_wdata(f_mem_wdata), .mem_rdata(f_mem_rdata)
  );

  // Synchronous single-port byte SRAM behind the main instance.
  logic [7:0] sram    [DEPTH] = '{default: 8'h00};
  logic [7:0] ref_mem [DEPTH] = '{default: 8'h00};
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata      <= sram[mem_addr];
    end
  end

  int pass_cnt = 0;
  int total    = 0;
  logic [31:0] last_rd [2];

  function automatic logic [31:0] ref_load(input logic [AW-1:0] base);
    logic [31:0] w = 32'h0;
    for (int i = 0; i < 4; i++) w = {w[23:0], ref_mem[AW'(base + i)]};
    return w;
  endfunction

  task automatic ref_store(input logic [AW-1:0] base, input logic [31:0] data);
    for (int i = 0; i < 4; i++) ref_mem[AW'(base + i)] = data[31-8*i -: 8];
  endtask

  function automatic logic [31:0] sram_word(input logic [AW-1:0] base);
    logic [31:0] w = 32'h0;
    for (int i = 0; i < 4; i++) w = {w[23:0], sram[AW'(base + i)]};
    return w;
  endfunction

  // Issues one request, returns the cycle of the response pulse counted from the acceptance edge.
  task automatic run_txn(input bit pb, input bit we, input logic [AW-1:0] addr,
                         input logic [31:0] wd, output int lat, output logic [31:0] rd,
                         output bit ok);
    int n = 0;
    ok = 1'b0; lat = 0; rd = 32'h0;
    @(negedge clk);
    if (pb) begin b_req_valid = 1; b_req_we = we; b_req_addr = addr; b_req_wdata = wd; end
    else    begin a_req_valid = 1; a_req_we = we; a_req_addr = addr; a_req_wdata = wd; end
    #1;
    while (!(pb ? b_req_ready : a_req_ready) && n < 50) begin @(negedge clk); #1; n++; end
    if (!(pb ? b_req_ready : a_req_ready)) begin a_req_valid = 0; b_req_valid = 0; return; end
    @(negedge clk);
    if (pb) begin b_req_valid = 0; b_req_addr = AW'($urandom); b_req_wdata = $urandom; end
    else    begin a_req_valid = 0; a_req_addr = AW'($urandom); a_req_wdata = $urandom; end
    #1; lat = 1;
    while (!(pb ? b_rsp_valid : a_rsp_valid) && lat < 20) begin @(negedge clk); #1; lat++; end
    ok = (pb ? b_rsp_valid : a_rsp_valid);
    rd = pb ? b_rsp_rdata : a_rsp_rdata;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    a_req_valid = 0; a_req_we = 0; a_req_addr = '0; a_req_wdata = 0;
    b_req_valid = 0; b_req_we = 0; b_req_addr = '0; b_req_wdata = 0;
    f_a_req_valid = 0; f_a_req_we = 0; f_a_req_addr = '0; f_a_req_wdata = 0;
    f_b_req_valid = 0; f_b_req_we = 0; f_b_req_addr = '0; f_b_req_wdata = 0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, mem_en, mem_we} !== 6'b0)
      $display("FAIL reset_ctrl: got %b required 000000",
               {a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, mem_en, mem_we});
    else pass_cnt++;
    total++;
    if ({a_rsp_rdata, b_rsp_rdata} !== 64'h0)
      $display("FAIL reset_rdata: got %h %h required 0 0", a_rsp_rdata, b_rsp_rdata);
    else pass_cnt++;
    total++;
    if ({mem_addr, mem_wdata} !== {AW'(0), 8'h00})
      $display("FAIL reset_mem: got addr %h wdata %h required 0 0", mem_addr, mem_wdata);
    else pass_cnt++;
    a_req_valid = 1; #1;
    total++;
    if (a_req_ready !== 1'b0) $display("FAIL reset_ready: got %b required 0", a_req_ready);
    else pass_cnt++;
    a_req_valid = 0;
    @(negedge clk); rst_n = 1;
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
  endtask

  task automatic test_store_load();
    int lat; logic [31:0] rd; bit ok;
    run_txn(0, 1, 12'h010, 32'hDEADBEEF, lat, rd, ok);
    ref_store(12'h010, 32'hDEADBEEF);
    total++;
    if (!ok || lat != 5) $display("FAIL store_latency: got %0d (ok=%0d) required 5", lat, ok);
    else pass_cnt++;
    total++;
    if (rd !== 32'h0) $display("FAIL store_rdata: got %h required 00000000", rd);
    else pass_cnt++;
    total++;
    if (sram_word(12'h010) !== 32'hDEADBEEF)
      $display("FAIL store_bytes: got %h required deadbeef", sram_word(12'h010));
    else pass_cnt++;
    run_txn(0, 0, 12'h010, 32'h0, lat, rd, ok);
    total++;
    if (!ok || lat != 6) $display("FAIL load_latency: got %0d (ok=%0d) required 6", lat, ok);
    else pass_cnt++;
    total++;
    if (rd !== 32'hDEADBEEF) $display("FAIL load_rdata: got %h required deadbeef", rd);
    else pass_cnt++;
    last_rd[0] = 32'hDEADBEEF;
  endtask

  task automatic test_wrap();
    int lat; logic [31:0] rd; bit ok;
    run_txn(1, 1, 12'hFFE, 32'h11223344, lat, rd, ok);
    ref_store(12'hFFE, 32'h11223344);
    last_rd[1] = 32'h0;
    total++;
    if ({sram[12'hFFE], sram[12'hFFF], sram[12'h000], sram[12'h001]} !== 32'h11223344)
      $display("FAIL wrap_bytes: got %h%h%h%h required 11223344",
               sram[12'hFFE], sram[12'hFFF], sram[12'h000], sram[12'h001]);
    else pass_cnt++;
    run_txn(0, 0, 12'hFFE, 32'h0, lat, rd, ok);
    total++;
    if (!ok || rd !== 32'h11223344) $display("FAIL wrap_load: got %h (ok=%0d) required 11223344", rd, ok);
    else pass_cnt++;
    last_rd[0] = 32'h11223344;
  endtask

  task automatic test_busy();
    int n = 0; int cyc; int first_b = 0; int a_cyc = 0; int lat;
    logic [31:0] a_rd = 32'h0;
    @(negedge clk);
    a_req_valid = 1; a_req_we = 0; a_req_addr = 12'h010; #1;
    while (!a_req_ready && n < 20) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    a_req_valid = 0; b_req_valid = 1; b_req_we = 0; b_req_addr = 12'hFFE; #1;
    cyc = 1;
    while (cyc < 20 && first_b == 0) begin
      if (a_rsp_valid && a_cyc == 0) begin a_cyc = cyc; a_rd = a_rsp_rdata; end
      if (b_req_ready) first_b = cyc;
      else begin @(negedge clk); #1; cyc++; end
    end
    total++;
    if (a_cyc != 6) $display("FAIL busy_a_rsp_cycle: got %0d required 6", a_cyc);
    else pass_cnt++;
    total++;
    if (a_rd !== ref_load(12'h010)) $display("FAIL busy_a_rdata: got %h required %h", a_rd, ref_load(12'h010));
    else pass_cnt++;
    total++;
    if (first_b != 7) $display("FAIL busy_b_ready_cycle: got %0d required 7", first_b);
    else pass_cnt++;
    @(negedge clk); b_req_valid = 0; #1; lat = 1;
    while (!b_rsp_valid && lat < 20) begin @(negedge clk); #1; lat++; end
    total++;
    if (!b_rsp_valid || b_rsp_rdata !== ref_load(12'hFFE))
      $display("FAIL busy_b_rdata: got %h (valid=%b) required %h", b_rsp_rdata, b_rsp_valid, ref_load(12'hFFE));
    else pass_cnt++;
    last_rd[0] = ref_load(12'h010); last_rd[1] = ref_load(12'hFFE);
  endtask

  task automatic test_simultaneous();
    int grants[$]; int times[$]; int cyc = 0; bit both = 0;
    logic [3:0] order = 4'h0; bit spacing_ok = 1;
    pulse_reset();
    @(negedge clk);
    a_req_valid = 1; a_req_we = 0; a_req_addr = 12'h010;
    b_req_valid = 1; b_req_we = 0; b_req_addr = 12'hFFE; #1;
    while (grants.size() < 4 && cyc < 60) begin
      if (a_req_ready && b_req_ready) both = 1;
      if (a_req_ready) begin grants.push_back(0); times.push_back(cyc); end
      else if (b_req_ready) begin grants.push_back(1); times.push_back(cyc); end
      if (grants.size() < 4) begin @(negedge clk); #1; cyc++; end
    end
    @(negedge clk); a_req_valid = 0; b_req_valid = 0;
    repeat (10) @(negedge clk);
    total++;
    if (grants.size() != 4 || both) $display("FAIL rr_grants: got %0d grants (both=%0d) required 4", grants.size(), both);
    else pass_cnt++;
    for (int i = 0; i < grants.size(); i++) order[3-i] = grants[i][0];
    for (int i = 1; i < times.size(); i++) if (times[i] - times[i-1] != 7) spacing_ok = 0;
    total++;
    if (order !== 4'b0101) $display("FAIL rr_order: got %b required 0101 (A=0)", order);
    else pass_cnt++;
    total++;
    if (!spacing_ok) $display("FAIL rr_load_spacing: got uneven grant spacing required 7 cycles");
    else pass_cnt++;
    total++;
    if (a_rsp_rdata !== ref_load(12'h010) || b_rsp_rdata !== ref_load(12'hFFE))
      $display("FAIL rr_rdata: got %h %h required %h %h", a_rsp_rdata, b_rsp_rdata,
               ref_load(12'h010), ref_load(12'hFFE));
    else pass_cnt++;
    last_rd[0] = ref_load(12'h010); last_rd[1] = ref_load(12'hFFE);
  endtask

  task automatic test_fixed_prio();
    int na = 0; int nb = 0; int n = 0;
    @(negedge clk);
    f_a_req_valid = 1; f_a_req_we = 1; f_a_req_addr = 12'h100; f_a_req_wdata = 32'hCAFEF00D;
    f_b_req_valid = 1; f_b_req_we = 1; f_b_req_addr = 12'h200; f_b_req_wdata = 32'h0BADC0DE;
    #1;
    for (int c = 0; c < 40; c++) begin
      if (c != 0) begin @(negedge clk); #1; end
      if (f_a_req_ready) na++;
      if (f_b_req_ready) nb++;
    end
    total++;
    if (nb != 0) $display("FAIL fixed_b_starved: got %0d B grants required 0", nb);
    else pass_cnt++;
    total++;
    if (na != 7) $display("FAIL fixed_a_grants: got %0d required 7", na);
    else pass_cnt++;
    while (!f_a_req_ready && n < 20) begin @(negedge clk); #1; n++; end
    @(negedge clk); f_a_req_valid = 0; #1;
    n = 0;
    while (!f_b_req_ready && n < 20) begin @(negedge clk); #1; n++; end
    total++;
    if (!f_b_req_ready) $display("FAIL fixed_b_after_a: got ready=0 required 1");
    else pass_cnt++;
    @(negedge clk); f_b_req_valid = 0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_random_back_to_back();
    logic [AW-1:0] stored[$];
    int lat; logic [31:0] rd; logic [31:0] exp; bit ok;
    for (int t = 0; t < 40; t++) begin
      bit pb = 1'($urandom_range(0, 1));
      bit we = 1'($urandom_range(0, 1));
      logic [AW-1:0] addr = AW'($urandom);
      logic [31:0] wd = $urandom;
      if (!we && stored.size() > 0 && $urandom_range(0, 1) == 1)
        addr = stored[$urandom_range(0, stored.size() - 1)];
      exp = we ? 32'h0 : ref_load(addr);
      run_txn(pb, we, addr, wd, lat, rd, ok);
      if (we) begin ref_store(addr, wd); stored.push_back(addr); end
      total++;
      if (!ok || lat != (we ? 5 : 6))
        $display("FAIL rand_latency[%0d]: got %0d (ok=%0d) required %0d", t, lat, ok, we ? 5 : 6);
      else pass_cnt++;
      total++;
      if (rd !== exp) $display("FAIL rand_rdata[%0d]: got %h required %h", t, rd, exp);
      else pass_cnt++;
      total++;
      if ((pb ? a_rsp_rdata : b_rsp_rdata) !== last_rd[!pb])
        $display("FAIL rand_hold[%0d]: got %h required %h", t, pb ? a_rsp_rdata : b_rsp_rdata, last_rd[!pb]);
      else pass_cnt++;
      last_rd[pb] = exp;
    end
  endtask

  task automatic test_reset_mid_store();
    int n = 0; bit saw_rsp = 0; int lat; logic [31:0] rd; bit ok;
    @(negedge clk);
    a_req_valid = 1; a_req_we = 1; a_req_addr = 12'h200; a_req_wdata = 32'hA1B2C3D4; #1;
    while (!a_req_ready && n < 20) begin @(negedge clk); #1; n++; end
    @(negedge clk); a_req_valid = 0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({mem_en, mem_we, mem_addr} !== {2'b11, 12'h202})
      $display("FAIL midrst_beat2: got en=%b we=%b addr=%h required 1 1 202", mem_en, mem_we, mem_addr);
    else pass_cnt++;
    rst_n = 0; #1;
    total++;
    if ({mem_en, mem_we} !== 2'b00) $display("FAIL midrst_async: got %b required 00", {mem_en, mem_we});
    else pass_cnt++;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 2) rst_n = 1;
      #1;
      if (a_rsp_valid || b_rsp_valid) saw_rsp = 1;
    end
    total++;
    if (saw_rsp) $display("FAIL midrst_no_rsp: got a response required none");
    else pass_cnt++;
    ref_mem[12'h200] = 8'hA1; ref_mem[12'h201] = 8'hB2;
    run_txn(1, 0, 12'h200, 32'h0, lat, rd, ok);
    total++;
    if (!ok || lat != 6 || rd !== ref_load(12'h200))
      $display("FAIL midrst_after: got %h lat %0d required %h lat 6", rd, lat, ref_load(12'h200));
    else pass_cnt++;
  endtask

  task automatic test_memory_image();
    int bad = 0;
    for (int i = 0; i < DEPTH; i++) if (sram[i] !== ref_mem[i]) bad++;
    total++;
    if (bad != 0) $display("FAIL mem_image: got %0d differing bytes required 0", bad);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_wrap();
    test_busy();
    test_simultaneous();
    test_fixed_prio();
    test_random_back_to_back();
    test_reset_mid_store();
    test_memory_image();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
